// File: rtl/ptou_stream.sv
// Purpose: serializes one 5x5-lane permutation state into SLICE_W-bit slices (y-major order) with per-slice index tags.
// Latency: first slice valid the cycle after accept; one slice per cycle, back-to-back loads add no bubble.
// Backpressure: stopin freezes the current slice; stopout holds upstream until the last slice is consumed. Optional: PTOU_STREAM_PARITY_EN adds doutpar.
module ptou_stream #(
  parameter int LANE_W  = 64,
  parameter int SLICE_W = 200,
  parameter int IX_W    = 3,
  localparam int STATE_W = 25 * LANE_W,
  localparam int NSLICE  = STATE_W / SLICE_W,
  localparam int CNT_W   = $clog2(NSLICE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pushin,
  input  logic [STATE_W-1:0]     din,
  input  logic [NSLICE*IX_W-1:0] dix,
  input  logic [CNT_W-1:0]       nslice,
  input  logic                   stopin,
  output logic                   stopout,
  output logic                   pushout,
  output logic [IX_W-1:0]        doutix,
  output logic [SLICE_W-1:0]     dout,
`ifdef PTOU_STREAM_PARITY_EN
  output logic                   doutpar,
`endif
  output logic                   err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [STATE_W-1:0]      sreg;
  logic [NSLICE*IX_W-1:0]  ixreg;
  logic [CNT_W-1:0]        rem;
  logic [STATE_W-1:0]      trans;
  logic [CNT_W-1:0]        eff_cnt;
  logic                    consume;
  logic                    last;
  logic                    accept;

  // Reorder the x-major input lanes into the y-major internal layout.
  always_comb begin
    trans = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        trans[LANE_W*(5*y+x) +: LANE_W] = din[LANE_W*(5*x+y) +: LANE_W];
      end
    end
  end

  // Zero or out-of-range counts mean a full, untruncated transfer.
  always_comb begin
    eff_cnt = nslice;
    if (nslice == '0 || nslice > CNT_W'(NSLICE)) eff_cnt = CNT_W'(NSLICE);
  end

  // Handshake decode and next-state logic; stopout drops on the final consume so a reload can land on the same edge.
  always_comb begin
    pushout = (state_q == SHIFT);
    consume = pushout && !stopin;
    last    = consume && (rem == CNT_W'(1));
    stopout = pushout && !last;
    accept  = pushin && !stopout;
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Slice and tag shifters; the last slice is not shifted out so dout/doutix hold it while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg  <= '0;
      ixreg <= '0;
      rem   <= '0;
    end else if (accept) begin
      sreg  <= trans;
      ixreg <= dix;
      rem   <= eff_cnt;
    end else if (consume) begin
      if (!last) begin
        sreg  <= sreg >> SLICE_W;
        ixreg <= ixreg >> IX_W;
      end
      rem <= rem - CNT_W'(1);
    end
  end

  // A load request while busy is a protocol violation; remember it until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 err <= 1'b0;
    else if (pushin && stopout) err <= 1'b1;
  end

  assign dout   = sreg[SLICE_W-1:0];
  assign doutix = ixreg[IX_W-1:0];

`ifdef PTOU_STREAM_PARITY_EN
  logic [STATE_W-1:0] sreg_nxt;
  assign sreg_nxt = sreg >> SLICE_W;

  // Parity is captured together with the slice it describes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 doutpar <= 1'b0;
    else if (accept)            doutpar <= ^trans[SLICE_W-1:0];
    else if (consume && !last)  doutpar <= ^sreg_nxt[SLICE_W-1:0];
  end
`endif

endmodule

// File: tb/tb_ptou_stream.sv
// Bench for ptou_stream: directed test-plan scenarios followed by random traffic, all checked cycle by cycle
// against a queue-of-expected-slices model built directly from the lane/slice layout rules.
module tb_ptou_stream;
  localparam int LANE_W  = 64;
  localparam int SLICE_W = 200;
  localparam int IX_W    = 3;
  localparam int STATE_W = 25 * LANE_W;
  localparam int NSLICE  = STATE_W / SLICE_W;
  localparam int CNT_W   = $clog2(NSLICE + 1);

  typedef struct packed {
    logic [IX_W-1:0]    tag;
    logic [SLICE_W-1:0] data;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pushin;
  logic [STATE_W-1:0]     din;
  logic [NSLICE*IX_W-1:0] dix;
  logic [CNT_W-1:0]       nslice;
  logic                   stopin;
  logic                   stopout;
  logic                   pushout;
  logic [IX_W-1:0]        doutix;
  logic [SLICE_W-1:0]     dout;
  logic                   err;
`ifdef PTOU_STREAM_PARITY_EN
  logic                   doutpar;
`endif

  ptou_stream #(.LANE_W(LANE_W), .SLICE_W(SLICE_W), .IX_W(IX_W)) dut (
    .clk(clk), .reset(reset), .pushin(pushin), .din(din), .dix(dix),
    .nslice(nslice), .stopin(stopin), .stopout(stopout), .pushout(pushout),
    .doutix(doutix), .dout(dout),
`ifdef PTOU_STREAM_PARITY_EN
    .doutpar(doutpar),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int   nassert = 0;
  int   nfail   = 0;
  int   po_cnt  = 0;
  ent_t q[$];
  ent_t last_ent;
  logic err_m;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slice k, bit j is internal bit SLICE_W*k+j; internal lane 5y+x came from input lane 5x+y.
  function automatic logic [SLICE_W-1:0] exp_slice(input logic [STATE_W-1:0] d, input int k);
    logic [SLICE_W-1:0] r;
    for (int j = 0; j < SLICE_W; j++) begin
      int i, l, z, x, y;
      i = SLICE_W * k + j;
      l = i / LANE_W;
      z = i % LANE_W;
      y = l / 5;
      x = l % 5;
      r[j] = d[LANE_W*(5*x+y) + z];
    end
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] lane_pattern();
    logic [STATE_W-1:0] d;
    logic [7:0] bx, by;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        bx = 8'(x);
        by = 8'(y);
        d[LANE_W*(5*x+y) +: LANE_W] = {bx, by, 48'h0};
      end
    return d;
  endfunction

  function automatic logic [STATE_W-1:0] rand_state();
    logic [STATE_W-1:0] d;
    for (int w = 0; w < STATE_W / 32; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, then advance model and DUT across the edge.
  task automatic cycle(input bit push, input logic [STATE_W-1:0] d, input logic [NSLICE*IX_W-1:0] ix,
                       input logic [CNT_W-1:0] ns, input bit st);
    bit busy, exp_stop;
    int c;
    pushin = push; din = d; dix = ix; nslice = ns; stopin = st;
    #1;
    busy     = (q.size() != 0);
    exp_stop = busy && !(q.size() == 1 && !st);
    chk("pushout", 256'(pushout), 256'(busy));
    chk("stopout", 256'(stopout), 256'(exp_stop));
    chk("err", 256'(err), 256'(err_m));
    if (busy) begin
      po_cnt++;
      chk("dout", 256'(dout), 256'(q[0].data));
      chk("doutix", 256'(doutix), 256'(q[0].tag));
`ifdef PTOU_STREAM_PARITY_EN
      chk("doutpar", 256'(doutpar), 256'(^q[0].data));
`endif
    end else begin
      chk("dout_idle", 256'(dout), 256'(last_ent.data));
      chk("doutix_idle", 256'(doutix), 256'(last_ent.tag));
    end
    if (push && exp_stop) err_m = 1'b1;
    if (busy && !st) last_ent = q.pop_front();
    if (push && !exp_stop) begin
      c = (ns == 0 || ns > NSLICE) ? NSLICE : int'(ns);
      for (int k = 0; k < c; k++) q.push_back({ix[IX_W*k +: IX_W], exp_slice(d, k)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, din, dix, nslice, 1'b0);
  endtask

  logic [STATE_W-1:0]     pat, sa, sb;
  logic [NSLICE*IX_W-1:0] ixd;

  initial begin
    reset = 1'b0; pushin = 1'b0; din = '0; dix = '0; nslice = '0; stopin = 1'b0;
    err_m = 1'b0; last_ent = '0;
    pat = lane_pattern();
    ixd = 24'o76543210;

    // Reset values.
    #3;
    chk("rst_pushout", 256'(pushout), 256'(0));
    chk("rst_stopout", 256'(stopout), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_dout", 256'(dout), 256'(0));
    chk("rst_doutix", 256'(doutix), 256'(0));
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full transfer of the lane pattern.
    po_cnt = 0;
    cycle(1'b1, pat, ixd, 4'd0, 1'b0);
    chk("slice0_lane00", 256'(dout[63:0]), 256'(pat[63:0]));
    idle(10);
    chk("full_len", 256'(po_cnt), 256'(8));

    // Truncated transfer of two slices.
    po_cnt = 0;
    cycle(1'b1, pat, ixd, 4'd2, 1'b0);
    idle(4);
    chk("trunc_len", 256'(po_cnt), 256'(2));

    // Three-cycle stall on slice 3.
    po_cnt = 0;
    cycle(1'b1, pat, ixd, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, pat, ixd, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, pat, ixd, 4'd0, 1'b1);
    idle(8);
    chk("stall_len", 256'(po_cnt), 256'(11));

    // Back-to-back loads with pushin held high; busy pulses flag err.
    sa = rand_state();
    sb = rand_state();
    po_cnt = 0;
    cycle(1'b1, sa, ixd, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, sb, 24'o01234567, 4'd0, 1'b0);
    idle(10);
    chk("b2b_len", 256'(po_cnt), 256'(16));
    chk("b2b_err", 256'(err), 256'(1));

    // Asynchronous reset while slice 4 is on the output.
    cycle(1'b1, sa, ixd, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, sa, ixd, 4'd0, 1'b0);
    reset = 1'b0;
    #2;
    chk("arst_pushout", 256'(pushout), 256'(0));
    chk("arst_stopout", 256'(stopout), 256'(0));
    chk("arst_err", 256'(err), 256'(0));
    chk("arst_dout", 256'(dout), 256'(0));
    q.delete(); err_m = 1'b0; last_ent = '0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, sb, ixd, 4'd0, 1'b0);
    idle(9);

    // Random traffic: random states, tags, counts, loads and stalls.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, rand_state(), 24'($urandom),
            CNT_W'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
